// File: rtl/uart_tx_ctrl_pkg.sv
// Shared definitions for the UART transmit frame sequencer.
//   tx_state_e        : sequencer state encoding, also exported for debug
//   UART_IDLE_LEVEL   : level of the serial line when no frame is in flight
//   *_MIN / *_MAX     : legal ranges for the DATA_BITS and STOP_BITS parameters
package uart_tx_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ALIGN  = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } tx_state_e;

    localparam logic UART_IDLE_LEVEL = 1'b1;

    localparam int DATA_BITS_MIN = 5;
    localparam int DATA_BITS_MAX = 9;
    localparam int STOP_BITS_MIN = 1;
    localparam int STOP_BITS_MAX = 2;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Word handshake between a producer and the UART transmit sequencer.
//   tx_data   : word to send, DATA_BITS wide
//   tx_valid  : producer has a word on tx_data
//   tx_ready  : sequencer can accept a word
// Handshake: a word transfers on a rising clock edge where tx_valid and
// tx_ready are both 1. The producer holds tx_data stable while tx_valid is 1
// and not yet accepted; tx_ready does not depend combinationally on tx_valid.
// After the transfer edge the sequencer ignores tx_data and tx_valid until it
// raises tx_ready again.
interface uart_tx_ctrl_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer.
// Serialises one word per handshake as: start bit, data bits LSB first,
// optional parity bit, stop bits. Every bit boundary is a baud_tick from the
// external 1x baud generator; the first tick after acceptance only aligns the
// start bit to the baud grid.
// Ports:
//   clk        : system clock
//   rst        : synchronous reset, active low
//   baud_tick  : one-clock pulse per bit period
//   bus        : word handshake (slave side: tx_data, tx_valid in; tx_ready out)
//   tx         : serial line, registered, idles high
//   tx_busy    : high from acceptance until the frame ends
//   tx_done    : one-clock pulse on the edge that ends the last stop bit
//   dbg_state  : current sequencer state
module uart_tx_ctrl
    import uart_tx_ctrl_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              baud_tick,
    uart_tx_ctrl_if.slave     bus,
    output logic              tx,
    output logic              tx_busy,
    output logic              tx_done,
    output tx_state_e         dbg_state
);

    localparam int BCW = $clog2(DATA_BITS);

    // An illegal parameter set instantiates a module that does not exist,
    // so elaboration stops instead of building a broken frame format.
    if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX ||
        STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_param
        uart_tx_ctrl_illegal_parameter u_bad ();
    end

    tx_state_e            state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_d;
    logic [BCW-1:0]       bit_cnt_q;
    logic [1:0]           stop_cnt_q;
    logic                 parity_q;
    logic                 parity_d;
    logic                 tx_q;
    logic                 ready_q;
    logic                 busy_q;
    logic                 done_q;

    assign parity_d = (^bus.tx_data) ^ 1'(PARITY_ODD);
    assign shift_d  = shift_q >> 1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= '0;
            parity_q   <= 1'b0;
            tx_q       <= UART_IDLE_LEVEL;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                // Ticks are ignored here, including one on the acceptance edge.
                ST_IDLE: begin
                    tx_q <= UART_IDLE_LEVEL;
                    if (bus.tx_valid && ready_q) begin
                        shift_q  <= bus.tx_data;
                        parity_q <= parity_d;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_ALIGN;
                    end
                end
                ST_ALIGN: begin
                    if (baud_tick) begin
                        tx_q    <= 1'b0;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_tick) begin
                        tx_q      <= shift_q[0];
                        bit_cnt_q <= '0;
                        state_q   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (baud_tick) begin
                        if (bit_cnt_q == BCW'(DATA_BITS - 1)) begin
                            stop_cnt_q <= '0;
                            if (PARITY_EN != 0) begin
                                tx_q    <= parity_q;
                                state_q <= ST_PARITY;
                            end else begin
                                tx_q    <= UART_IDLE_LEVEL;
                                state_q <= ST_STOP;
                            end
                        end else begin
                            // Next bit on the line is the new LSB after the shift.
                            shift_q   <= shift_d;
                            tx_q      <= shift_d[0];
                            bit_cnt_q <= bit_cnt_q + BCW'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (baud_tick) begin
                        tx_q       <= UART_IDLE_LEVEL;
                        stop_cnt_q <= '0;
                        state_q    <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (baud_tick) begin
                        if (stop_cnt_q == 2'(STOP_BITS - 1)) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            ready_q <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            stop_cnt_q <= stop_cnt_q + 2'd1;
                        end
                    end
                end
                default: begin
                    tx_q    <= UART_IDLE_LEVEL;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.tx_ready = ready_q;
    assign tx           = tx_q;
    assign tx_busy      = busy_q;
    assign tx_done      = done_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: four instances with different frame formats share
// clk, rst and baud_tick (one pulse every 4 clocks). A reference model keeps,
// per instance, the queue of line levels still to appear on the coming ticks.
module tb_uart_tx_ctrl;
  import uart_tx_ctrl_pkg::*;

  localparam int N = 4;
  localparam int P_EN[N]  = '{0, 1, 1, 0};
  localparam int P_ODD[N] = '{0, 0, 1, 0};
  localparam int STOPS[N] = '{1, 1, 1, 2};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic baud_tick = 1'b0;
  int   tick_ph = 0;

  logic       valid_a[N];
  logic [7:0] data_a[N];
  logic       ready_a[N];
  logic       tx_a[N];
  logic       busy_a[N];
  logic       done_a[N];
  tx_state_e  state_a[N];

  int n_cmp = 0;
  int n_err = 0;
  logic mon_en = 1'b0;

  // reference model state
  logic exp_bits[N][$];
  logic exp_tx[N];
  logic exp_ready[N];
  logic exp_busy[N];
  logic exp_done[N];

  uart_tx_ctrl_if #(.DATA_BITS(8)) bus[N] ();

  for (genvar g = 0; g < N; g++) begin : g_dut
    assign bus[g].tx_data  = data_a[g];
    assign bus[g].tx_valid = valid_a[g];
    assign ready_a[g]      = bus[g].tx_ready;

    uart_tx_ctrl #(
      .DATA_BITS (8),
      .PARITY_EN (P_EN[g]),
      .PARITY_ODD(P_ODD[g]),
      .STOP_BITS (STOPS[g])
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .baud_tick(baud_tick),
      .bus      (bus[g]),
      .tx       (tx_a[g]),
      .tx_busy  (busy_a[g]),
      .tx_done  (done_a[g]),
      .dbg_state(state_a[g])
    );
  end

  // clock / tick
  initial forever #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      tick_ph = (tick_ph + 1) % 4;
      baud_tick = (tick_ph == 0);
    end
  end

  // Reference model: at each falling edge compare the outputs produced by the
  // last rising edge, then predict what the next rising edge produces.
  initial begin
    for (int k = 0; k < N; k++) begin
      exp_tx[k] = 1'b1; exp_ready[k] = 1'b1; exp_busy[k] = 1'b0; exp_done[k] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        if (mon_en) begin
          n_cmp++;
          assert (tx_a[k] === exp_tx[k]) else begin
            n_err++; $error("FAIL tx[%0d] t=%0t observed %b expected %b", k, $time, tx_a[k], exp_tx[k]);
          end
          n_cmp++;
          assert (ready_a[k] === exp_ready[k]) else begin
            n_err++; $error("FAIL ready[%0d] t=%0t observed %b expected %b", k, $time, ready_a[k], exp_ready[k]);
          end
          n_cmp++;
          assert (busy_a[k] === exp_busy[k]) else begin
            n_err++; $error("FAIL busy[%0d] t=%0t observed %b expected %b", k, $time, busy_a[k], exp_busy[k]);
          end
          n_cmp++;
          assert (done_a[k] === exp_done[k]) else begin
            n_err++; $error("FAIL done[%0d] t=%0t observed %b expected %b", k, $time, done_a[k], exp_done[k]);
          end
        end
        exp_done[k] = 1'b0;
        if (rst !== 1'b1) begin
          exp_bits[k].delete();
          exp_tx[k] = 1'b1; exp_ready[k] = 1'b1; exp_busy[k] = 1'b0;
        end else if (!exp_busy[k]) begin
          if (valid_a[k] === 1'b1) begin
            // line levels for the ticks after acceptance: start, data, parity, stops
            exp_bits[k].delete();
            exp_bits[k].push_back(1'b0);
            for (int i = 0; i < 8; i++) exp_bits[k].push_back(data_a[k][i]);
            if (P_EN[k] != 0)
              exp_bits[k].push_back(1'(($countones(data_a[k]) + P_ODD[k]) % 2));
            for (int i = 0; i < STOPS[k]; i++) exp_bits[k].push_back(1'b1);
            exp_ready[k] = 1'b0; exp_busy[k] = 1'b1;
          end
        end else if (baud_tick === 1'b1) begin
          if (exp_bits[k].size() == 0) begin
            exp_done[k] = 1'b1; exp_busy[k] = 1'b0; exp_ready[k] = 1'b1; exp_tx[k] = 1'b1;
          end else begin
            exp_tx[k] = exp_bits[k].pop_front();
          end
        end
      end
    end
  end

  // driver tasks
  task automatic send(input int k, input logic [7:0] d);
    int t = 0;
    while (ready_a[k] !== 1'b1 && t < 400) begin
      @(posedge clk); #2; t++;
    end
    n_cmp++;
    assert (t < 400) else begin
      n_err++; $error("FAIL send_timeout[%0d] observed %0d clks expected < 400", k, t);
    end
    valid_a[k] = 1'b1;
    data_a[k] = d;
    @(posedge clk); #2;
    valid_a[k] = 1'b0;
    data_a[k] = 8'($urandom);
  endtask

  task automatic wait_idle(input int k);
    int t = 0;
    while (ready_a[k] !== 1'b1 && t < 400) begin
      @(posedge clk); #2; t++;
    end
    n_cmp++;
    assert (t < 400) else begin
      n_err++; $error("FAIL idle_timeout[%0d] observed %0d clks expected < 400", k, t);
    end
  endtask

  task automatic tick_wait(input int n);
    repeat (n) begin
      do @(posedge clk); while (baud_tick !== 1'b1);
    end
    #2;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++; $error("FAIL %s observed %b expected %b", tag, obs, exp_v);
    end
  endtask

  initial begin
    int t;
    for (int k = 0; k < N; k++) begin
      valid_a[k] = 1'b0; data_a[k] = 8'h00;
    end

    // 1. reset state
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    for (int k = 0; k < N; k++) begin
      chk($sformatf("reset_tx%0d", k), tx_a[k], 1'b1);
      chk($sformatf("reset_ready%0d", k), ready_a[k], 1'b1);
      chk($sformatf("reset_busy%0d", k), busy_a[k], 1'b0);
      chk($sformatf("reset_done%0d", k), done_a[k], 1'b0);
    end
    rst = 1'b1;
    mon_en = 1'b1;

    // 2. default format, 0x55
    send(0, 8'h55);
    wait_idle(0);

    // 3. parity even and odd, 0x07
    send(1, 8'h07);
    send(2, 8'h07);
    wait_idle(1);
    wait_idle(2);

    // 4. handshake coinciding with a baud_tick
    t = 0;
    do begin @(posedge clk); #2; t++; end while (baud_tick !== 1'b1 && t < 8);
    valid_a[0] = 1'b1;
    data_a[0] = 8'($urandom);
    @(posedge clk); #2;
    valid_a[0] = 1'b0;
    chk("tick_hs_accepted", ready_a[0], 1'b0);
    repeat (3) @(posedge clk);
    #2;
    chk("tick_hs_tx_before_next_tick", tx_a[0], 1'b1);
    @(posedge clk); #2;
    chk("tick_hs_tx_at_next_tick", tx_a[0], 1'b0);
    wait_idle(0);

    // 5. reset during data bit 3, then a clean frame
    send(0, 8'($urandom));
    tick_wait(5);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #2;
    chk("abort_tx", tx_a[0], 1'b1);
    chk("abort_ready", ready_a[0], 1'b1);
    chk("abort_busy", busy_a[0], 1'b0);
    chk("abort_done", done_a[0], 1'b0);
    rst = 1'b1;
    send(0, 8'($urandom));
    wait_idle(0);

    // 6. two stop bits, valid held high across two words
    valid_a[3] = 1'b1;
    data_a[3] = 8'hA3;
    @(posedge clk); #2;
    data_a[3] = 8'h3C;
    t = 0;
    while (done_a[3] !== 1'b1 && t < 400) begin
      @(posedge clk); #2; t++;
    end
    chk("b2b_first_done", done_a[3], 1'b1);
    @(posedge clk); #2;
    chk("b2b_second_accept_ready", ready_a[3], 1'b0);
    chk("b2b_second_accept_busy", busy_a[3], 1'b1);
    valid_a[3] = 1'b0;
    wait_idle(3);

    // 7. random words on random instances
    repeat (40) begin
      int k;
      k = $urandom_range(0, N - 1);
      send(k, 8'($urandom));
      repeat ($urandom_range(0, 12)) @(posedge clk);
      #2;
    end
    for (int k = 0; k < N; k++) wait_idle(k);
    for (int k = 0; k < N; k++) begin
      n_cmp++;
      assert (state_a[k] === ST_IDLE) else begin
        n_err++; $error("FAIL final_state[%0d] observed %0d expected %0d", k, state_a[k], ST_IDLE);
      end
    end
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
